id_stage_ctrl_pipe: RTL and testbench
=====================================

# id_stage_ctrl_pipe

Control-word consumer and carrier for the five-stage core. It captures the 8-bit decoded control word and register fields in ID and pipelines them through the ID/EX, EX/MEM and MEM/WB boundaries. It inserts bubbles for load-use hazards and taken-branch flushes, and drives per-stage control outputs. It sits between the opcode decoder and the EX/MEM/WB datapath, and owns the stall and flush handshake with the fetch stage.

## Interface
Parameters:
- CNT_W, 16, width of the saturating bubble counter

Ports:
- clk  in  1  rising-edge clock
- rst_n  in  1  asynchronous, active-low reset
- id_instr  in  32  instruction currently in ID
- id_ctrl  in  8  decoded control word:
  - [0] ALUSrc, [1] MemtoReg, [2] RegWrite, [3] MemRead
  - [4] MemWrite, [5] Branch, [7:6] ALUOp
- id_valid  in  1  ID holds a real instruction
- ex_branch_taken  in  1  branch in EX resolved taken
- freeze  in  1  global hold (memory not ready)
- hazard_stall  out  1  hold PC and IF/ID this cycle
- flush_id  out  1  squash IF/ID this cycle
- ex_valid, ex_alusrc, ex_branch  out  1 each
- ex_aluop  out  2
- ex_funct  out  4  {instr[30], instr[14:12]}
- ex_rd  out  5
- mem_valid, mem_memread, mem_memwrite  out  1 each
- mem_rd  out  5
- wb_valid, wb_regwrite, wb_memtoreg  out  1 each
- wb_rd  out  5
- bubble_cnt  out  CNT_W  bubbles inserted into EX since reset

## Operation
ID decode:
- rs1 = instr[19:15], rs2 = instr[24:20], rd = instr[11:7], opcode = instr[6:0].
- uses_rs1 for opcodes 0110011, 0010011, 0000011, 0100011, 1100011.
- uses_rs2 for 0110011, 0100011, 1100011.

Sanitising at ID→EX capture:
- RegWrite is forced 0 when rd == 0.
- MemtoReg is forced 0 when RegWrite == 0, so no X enters the pipe.
- All control bits are forced 0 when id_valid = 0.

Combinational outputs:
- flush_id = ex_valid & ex_branch_taken & ~freeze.
- load_use = ex_valid & ex_memread & ex_rd != 0 & ((uses_rs1 & ex_rd == rs1) | (uses_rs2 & ex_rd == rs2)) & id_valid.
- hazard_stall = load_use & ~flush_id & ~freeze. Flush has priority: the dependent instruction is squashed anyway.

Per-cycle update, in priority order:
- freeze = 1: every stage register and bubble_cnt hold.
- flush_id or hazard_stall: EX loads a bubble (all control and valid = 0, rd = 0); MEM ← EX; WB ← MEM.
- otherwise: EX ← sanitised ID; MEM ← EX; WB ← MEM.

Bubble counter:
- bubble_cnt increments by 1 on each cycle a bubble is loaded for flush or stall.
- It saturates at 2^CNT_W−1 and never wraps.
- A bubble from id_valid = 0 is not counted.

## Timing
- All stage registers update on the rising edge of clk.
- rst_n low asynchronously clears every registered output to 0: all valid, control, rd, funct and bubble_cnt.
- hazard_stall and flush_id are combinational in the same cycle as their cause.
- Latency: ID inputs at edge N appear on ex_* after edge N, mem_* after N+1, wb_* after N+2.
- Load-use costs exactly one bubble. The next cycle the load is in MEM, load_use drops, and the held ID instruction advances.
- Reset asserted mid-stream discards all in-flight instructions; the first cycle after release behaves as an empty pipe.
- freeze held for k cycles keeps outputs stable for k cycles, then resumes exactly where it stopped.

## Test plan
- Reset check: pulse rst_n low mid-stream between clock edges → all outputs read 0 immediately; bubble_cnt = 0.
- Straight flow: add x6,x1,x2 (ctrl 0x84, id_valid = 1) → after edge 1: ex_aluop = 2, ex_rd = 6, ex_funct = 0; after edge 3: wb_regwrite = 1, wb_rd = 6, wb_memtoreg = 0.
- Load-use on rs1: lw x5 then add x6,x5,x1 → hazard_stall = 1 for exactly one cycle; following cycle ex_valid = 0; bubble_cnt = 1; add reaches EX one cycle later.
- Load-use on rs2 via sw x5,0(x1) → stall. lw x0 followed by a use of x0 → no stall. Load followed by an I-type using rs2 bits = 5 → no stall.
- Branch taken in EX while a load-use condition is also present → flush_id = 1, hazard_stall = 0; next cycle ex_valid = 0; bubble_cnt increments once.
- Freeze: assert freeze for 3 cycles mid-stream → all ex/mem/wb outputs and bubble_cnt unchanged; hazard_stall = flush_id = 0; resume matches an unfrozen reference sequence. Saturation: with CNT_W = 2, insert 5 flushes → bubble_cnt = 3.

Source files
------------

// File: rtl/id_stage_ctrl_pipe.sv
// Carries the decoded control word from ID through EX/MEM/WB. Inserts bubbles for
// load-use hazards and taken-branch flushes, and counts them with a saturating counter.
module id_stage_ctrl_pipe #(
  parameter int CNT_W = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [31:0]      id_instr,
  input  logic [7:0]       id_ctrl,
  input  logic             id_valid,
  input  logic             ex_branch_taken,
  input  logic             freeze,
  output logic             hazard_stall,
  output logic             flush_id,
  output logic             ex_valid,
  output logic             ex_alusrc,
  output logic             ex_branch,
  output logic [1:0]       ex_aluop,
  output logic [3:0]       ex_funct,
  output logic [4:0]       ex_rd,
  output logic             mem_valid,
  output logic             mem_memread,
  output logic             mem_memwrite,
  output logic [4:0]       mem_rd,
  output logic             wb_valid,
  output logic             wb_regwrite,
  output logic             wb_memtoreg,
  output logic [4:0]       wb_rd,
  output logic [CNT_W-1:0] bubble_cnt
);

  logic [4:0] rs1, rs2, rd;
  logic [6:0] opcode;
  logic       uses_rs1, uses_rs2;
  logic       load_use, bubble;

  // EX-stage control that only feeds later stages
  logic ex_memread, ex_memwrite, ex_regwrite, ex_memtoreg;
  logic mem_regwrite, mem_memtoreg;

  // Sanitised ID values presented to the EX register
  logic       n_valid, n_alusrc, n_branch, n_memread, n_memwrite, n_regwrite, n_memtoreg;
  logic [1:0] n_aluop;
  logic [3:0] n_funct;
  logic [4:0] n_rd;

  logic unused_instr_bits;
  assign unused_instr_bits = &{1'b0, id_instr[31], id_instr[29:25]};

  assign rs1    = id_instr[19:15];
  assign rs2    = id_instr[24:20];
  assign rd     = id_instr[11:7];
  assign opcode = id_instr[6:0];

  always_comb begin
    uses_rs1 = 1'b0;
    uses_rs2 = 1'b0;
    case (opcode)
      7'b0110011: begin uses_rs1 = 1'b1; uses_rs2 = 1'b1; end
      7'b0100011: begin uses_rs1 = 1'b1; uses_rs2 = 1'b1; end
      7'b1100011: begin uses_rs1 = 1'b1; uses_rs2 = 1'b1; end
      7'b0010011: uses_rs1 = 1'b1;
      7'b0000011: uses_rs1 = 1'b1;
      default: ;
    endcase
  end

  assign flush_id = ex_valid & ex_branch_taken & ~freeze;
  assign load_use = ex_valid & ex_memread & (ex_rd != 5'd0) &
                    ((uses_rs1 & (ex_rd == rs1)) | (uses_rs2 & (ex_rd == rs2))) & id_valid;
  // A flushed dependent is squashed anyway, so flush wins over stall.
  assign hazard_stall = load_use & ~flush_id & ~freeze;
  assign bubble       = flush_id | hazard_stall;

  always_comb begin
    n_valid    = id_valid;
    n_alusrc   = id_valid & id_ctrl[0];
    n_regwrite = id_valid & id_ctrl[2] & (rd != 5'd0);
    n_memtoreg = id_ctrl[1] & n_regwrite;
    n_memread  = id_valid & id_ctrl[3];
    n_memwrite = id_valid & id_ctrl[4];
    n_branch   = id_valid & id_ctrl[5];
    n_aluop    = id_valid ? id_ctrl[7:6] : 2'b00;
    n_funct    = id_valid ? {id_instr[30], id_instr[14:12]} : 4'd0;
    n_rd       = id_valid ? rd : 5'd0;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ex_valid     <= 1'b0;
      ex_alusrc    <= 1'b0;
      ex_branch    <= 1'b0;
      ex_aluop     <= 2'b00;
      ex_funct     <= 4'd0;
      ex_rd        <= 5'd0;
      ex_memread   <= 1'b0;
      ex_memwrite  <= 1'b0;
      ex_regwrite  <= 1'b0;
      ex_memtoreg  <= 1'b0;
      mem_valid    <= 1'b0;
      mem_memread  <= 1'b0;
      mem_memwrite <= 1'b0;
      mem_rd       <= 5'd0;
      mem_regwrite <= 1'b0;
      mem_memtoreg <= 1'b0;
      wb_valid     <= 1'b0;
      wb_regwrite  <= 1'b0;
      wb_memtoreg  <= 1'b0;
      wb_rd        <= 5'd0;
      bubble_cnt   <= '0;
    end else if (!freeze) begin
      if (bubble) begin
        ex_valid    <= 1'b0;
        ex_alusrc   <= 1'b0;
        ex_branch   <= 1'b0;
        ex_aluop    <= 2'b00;
        ex_funct    <= 4'd0;
        ex_rd       <= 5'd0;
        ex_memread  <= 1'b0;
        ex_memwrite <= 1'b0;
        ex_regwrite <= 1'b0;
        ex_memtoreg <= 1'b0;
        if (bubble_cnt != {CNT_W{1'b1}})
          bubble_cnt <= bubble_cnt + {{(CNT_W-1){1'b0}}, 1'b1};
      end else begin
        ex_valid    <= n_valid;
        ex_alusrc   <= n_alusrc;
        ex_branch   <= n_branch;
        ex_aluop    <= n_aluop;
        ex_funct    <= n_funct;
        ex_rd       <= n_rd;
        ex_memread  <= n_memread;
        ex_memwrite <= n_memwrite;
        ex_regwrite <= n_regwrite;
        ex_memtoreg <= n_memtoreg;
      end
      mem_valid    <= ex_valid;
      mem_memread  <= ex_memread;
      mem_memwrite <= ex_memwrite;
      mem_rd       <= ex_rd;
      mem_regwrite <= ex_regwrite;
      mem_memtoreg <= ex_memtoreg;
      wb_valid     <= mem_valid;
      wb_regwrite  <= mem_regwrite;
      wb_memtoreg  <= mem_memtoreg;
      wb_rd        <= mem_rd;
    end
  end

endmodule

// File: tb/tb_id_stage_ctrl_pipe.sv
// Directed bench for id_stage_ctrl_pipe: hazards, flush priority, freeze, reset, saturation.
// Uses CNT_W = 2 so the saturation case is reachable with a handful of flushes.
module tb_id_stage_ctrl_pipe;

  localparam int CNT_W = 2;

  logic             clk = 1'b0;
  logic             rst_n;
  logic [31:0]      id_instr;
  logic [7:0]       id_ctrl;
  logic             id_valid;
  logic             ex_branch_taken;
  logic             freeze;
  logic             hazard_stall, flush_id;
  logic             ex_valid, ex_alusrc, ex_branch;
  logic [1:0]       ex_aluop;
  logic [3:0]       ex_funct;
  logic [4:0]       ex_rd;
  logic             mem_valid, mem_memread, mem_memwrite;
  logic [4:0]       mem_rd;
  logic             wb_valid, wb_regwrite, wb_memtoreg;
  logic [4:0]       wb_rd;
  logic [CNT_W-1:0] bubble_cnt;

  int n_chk  = 0;
  int n_fail = 0;

  id_stage_ctrl_pipe #(.CNT_W(CNT_W)) dut (
    .clk(clk), .rst_n(rst_n), .id_instr(id_instr), .id_ctrl(id_ctrl), .id_valid(id_valid),
    .ex_branch_taken(ex_branch_taken), .freeze(freeze),
    .hazard_stall(hazard_stall), .flush_id(flush_id),
    .ex_valid(ex_valid), .ex_alusrc(ex_alusrc), .ex_branch(ex_branch),
    .ex_aluop(ex_aluop), .ex_funct(ex_funct), .ex_rd(ex_rd),
    .mem_valid(mem_valid), .mem_memread(mem_memread), .mem_memwrite(mem_memwrite),
    .mem_rd(mem_rd), .wb_valid(wb_valid), .wb_regwrite(wb_regwrite),
    .wb_memtoreg(wb_memtoreg), .wb_rd(wb_rd), .bubble_cnt(bubble_cnt)
  );

  always #5 clk = ~clk;

  function automatic logic [31:0] enc(input logic [6:0] f7, input logic [4:0] r2,
                                      input logic [4:0] r1, input logic [2:0] f3,
                                      input logic [4:0] rdf, input logic [6:0] op);
    return {f7, r2, r1, f3, rdf, op};
  endfunction

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic [31:0] ins, input logic [7:0] ctl, input logic vld);
    id_instr = ins;
    id_ctrl  = ctl;
    id_valid = vld;
    #1;
  endtask

  task automatic pulse_reset();
    #2 rst_n = 1'b0;
    #1;
    check("rst_ex_valid", ex_valid, 0);
    check("rst_mem_valid", mem_valid, 0);
    check("rst_wb_rd", wb_rd, 0);
    check("rst_bubble_cnt", bubble_cnt, 0);
    rst_n = 1'b1;
  endtask

  logic [31:0] add_6_1_2, lw_5, add_6_5_1, sw_5, lw_0, add_6_0_0, addi_7_1_5, beq;

  initial begin
    add_6_1_2  = enc(7'd0, 5'd2, 5'd1, 3'd0, 5'd6, 7'b0110011);
    lw_5       = enc(7'd0, 5'd0, 5'd1, 3'd2, 5'd5, 7'b0000011);
    add_6_5_1  = enc(7'd0, 5'd1, 5'd5, 3'd0, 5'd6, 7'b0110011);
    sw_5       = enc(7'd0, 5'd5, 5'd1, 3'd2, 5'd0, 7'b0100011);
    lw_0       = enc(7'd0, 5'd0, 5'd1, 3'd2, 5'd0, 7'b0000011);
    add_6_0_0  = enc(7'd0, 5'd0, 5'd0, 3'd0, 5'd6, 7'b0110011);
    addi_7_1_5 = enc(7'd0, 5'd5, 5'd1, 3'd0, 5'd7, 7'b0010011);
    beq        = enc(7'd0, 5'd2, 5'd1, 3'd0, 5'd0, 7'b1100011);

    rst_n = 1'b0; id_instr = '0; id_ctrl = '0; id_valid = 1'b0;
    ex_branch_taken = 1'b0; freeze = 1'b0;
    #3;
    check("init_ex_valid", ex_valid, 0);
    check("init_wb_regwrite", wb_regwrite, 0);
    check("init_bubble_cnt", bubble_cnt, 0);
    #5 rst_n = 1'b1;

    // Straight flow: add x6,x1,x2
    drive(add_6_1_2, 8'h84, 1'b1);
    step();
    check("flow_ex_valid", ex_valid, 1);
    check("flow_ex_aluop", ex_aluop, 2);
    check("flow_ex_rd", ex_rd, 6);
    check("flow_ex_funct", ex_funct, 0);
    drive(32'd0, 8'h00, 1'b0);
    step();
    check("flow_mem_rd", mem_rd, 6);
    step();
    check("flow_wb_regwrite", wb_regwrite, 1);
    check("flow_wb_rd", wb_rd, 6);
    check("flow_wb_memtoreg", wb_memtoreg, 0);
    check("flow_no_count_invalid", bubble_cnt, 0);

    // Load-use on rs1
    drive(lw_5, 8'h0F, 1'b1);
    step();
    check("lw_ex_funct", ex_funct, 2);
    drive(add_6_5_1, 8'h84, 1'b1);
    check("lu1_stall", hazard_stall, 1);
    check("lu1_flush", flush_id, 0);
    step();
    check("lu1_bubble_ex_valid", ex_valid, 0);
    check("lu1_mem_memread", mem_memread, 1);
    check("lu1_cnt", bubble_cnt, 1);
    check("lu1_stall_drops", hazard_stall, 0);
    step();
    check("lu1_add_in_ex_valid", ex_valid, 1);
    check("lu1_add_in_ex_rd", ex_rd, 6);

    // Load-use on rs2 via store
    drive(lw_5, 8'h0F, 1'b1);
    step();
    drive(sw_5, 8'h11, 1'b1);
    check("lu2_stall", hazard_stall, 1);
    step();
    check("lu2_cnt", bubble_cnt, 2);
    step();
    check("lu2_sw_in_ex", ex_valid, 1);

    // lw x0 then use of x0: no hazard, regwrite/memtoreg scrubbed
    drive(lw_0, 8'h0F, 1'b1);
    step();
    drive(add_6_0_0, 8'h84, 1'b1);
    check("x0_no_stall", hazard_stall, 0);
    drive(32'd0, 8'h00, 1'b0);
    step();
    step();
    check("x0_wb_valid", wb_valid, 1);
    check("x0_wb_regwrite", wb_regwrite, 0);
    check("x0_wb_memtoreg", wb_memtoreg, 0);

    // Load then I-type whose imm bits look like rs2 = 5
    drive(lw_5, 8'h0F, 1'b1);
    step();
    drive(addi_7_1_5, 8'h05, 1'b1);
    check("itype_no_stall", hazard_stall, 0);
    step();
    check("itype_cnt", bubble_cnt, 2);

    // Reset mid-stream, between edges
    drive(add_6_1_2, 8'h84, 1'b1);
    step();
    pulse_reset();

    // Flush has priority over a coincident load-use
    drive(lw_5, 8'h28, 1'b1);
    step();
    check("br_ex_branch", ex_branch, 1);
    drive(add_6_5_1, 8'h84, 1'b1);
    ex_branch_taken = 1'b1;
    #1;
    check("br_flush", flush_id, 1);
    check("br_stall_masked", hazard_stall, 0);
    step();
    ex_branch_taken = 1'b0;
    check("br_ex_valid", ex_valid, 0);
    check("br_cnt", bubble_cnt, 1);

    // Freeze for 3 cycles with a pending load-use
    drive(add_6_1_2, 8'h84, 1'b1);
    step();
    drive(lw_5, 8'h0F, 1'b1);
    step();
    freeze = 1'b1;
    drive(add_6_5_1, 8'h84, 1'b1);
    check("frz_stall", hazard_stall, 0);
    check("frz_flush", flush_id, 0);
    for (int k = 0; k < 3; k++) begin
      step();
      check("frz_ex_rd", ex_rd, 5);
      check("frz_mem_rd", mem_rd, 6);
      check("frz_wb_valid", wb_valid, 0);
      check("frz_cnt", bubble_cnt, 1);
    end
    freeze = 1'b0;
    #1;
    check("unfrz_stall", hazard_stall, 1);
    step();
    check("unfrz_ex_valid", ex_valid, 0);
    check("unfrz_mem_rd", mem_rd, 5);
    check("unfrz_wb_rd", wb_rd, 6);
    check("unfrz_wb_regwrite", wb_regwrite, 1);
    check("unfrz_cnt", bubble_cnt, 2);
    step();
    check("unfrz_add_ex_rd", ex_rd, 6);

    // Saturation: 5 flushes into a 2-bit counter
    pulse_reset();
    for (int i = 0; i < 5; i++) begin
      drive(beq, 8'h60, 1'b1);
      step();
      ex_branch_taken = 1'b1;
      step();
      ex_branch_taken = 1'b0;
      check("sat_cnt", bubble_cnt, (i + 1 > 3) ? 3 : i + 1);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
